// File: rtl/sys_bus_periph_pkg.sv
// Shared constants for the system-bus peripheral block: region IDs, register word offsets,
// CTRL bit positions and the region decoder used by the top level.
package sys_bus_periph_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Address bits [31:28] select the region.
  localparam logic [3:0] TIMER_REGION = 4'h1;
  localparam logic [3:0] GPIO_REGION  = 4'h2;

  // Timer register word offsets (address bits [3:2]).
  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_COUNT  = 2'd1;
  localparam logic [1:0] TMR_CMP    = 2'd2;
  localparam logic [1:0] TMR_STATUS = 2'd3;

  // GPIO register word offsets (address bits [3:2]).
  localparam logic [1:0] GPIO_OUT = 2'd0;
  localparam logic [1:0] GPIO_DIR = 2'd1;
  localparam logic [1:0] GPIO_IN  = 2'd2;

  // CTRL bit indices.
  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_IE   = 1;
  localparam int unsigned CTRL_AUTO = 2;

  typedef enum logic [1:0] {
    RegionNone,
    RegionTimer,
    RegionGpio
  } region_e;

  // Each region is a 16-byte window at its base; anything else is unmapped.
  function automatic region_e decode_region(logic [31:0] adr);
    region_e region;
    region = RegionNone;
    if (adr[27:4] == '0) begin
      if (adr[31:28] == TIMER_REGION) begin
        region = RegionTimer;
      end else if (adr[31:28] == GPIO_REGION && adr[3:2] != 2'd3) begin
        region = RegionGpio;
      end
    end
    return region;
  endfunction

endpackage

// File: rtl/sys_bus_periph_timer.sv
// Machine timer: prescaler, COUNT, CMP, CTRL, PEND and the registered interrupt flag.
// Simple register interface: sel/we/addr(word)/wdata in, combinational rdata out.
module sys_timer
  import sys_bus_periph_pkg::*;
#(
  parameter int unsigned PRESCALE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        int_flag_o
);

  localparam logic [15:0] PrescMax = 16'(PRESCALE - 1);

  logic [15:0] presc_q;
  logic [2:0]  ctrl_q;
  logic [31:0] count_q;
  logic [31:0] cmp_q;
  logic        pend_q;
  logic        int_flag_q;

  logic wr;
  logic tick;
  logic count_wr;
  logic match;

  // Tick and match qualification from current register state.
  always_comb begin
    wr       = sel & we;
    tick     = ctrl_q[CTRL_EN] && (presc_q == PrescMax);
    count_wr = wr && (addr == TMR_COUNT);
    // A COUNT write on a tick cycle suppresses the match check.
    match    = tick && !count_wr && (count_q == cmp_q);
  end

  // Prescaler runs only while enabled and is parked at zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (!ctrl_q[CTRL_EN] || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 16'd1;
    end
  end

  // CTRL and CMP are plain bus-written registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      cmp_q  <= '0;
    end else begin
      if (wr && addr == TMR_CTRL) ctrl_q <= wdata[2:0];
      if (wr && addr == TMR_CMP)  cmp_q  <= wdata;
    end
  end

  // COUNT: a bus write beats the tick; AUTO reloads zero on a match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (count_wr) begin
      count_q <= wdata;
    end else if (tick) begin
      count_q <= (match && ctrl_q[CTRL_AUTO]) ? 32'd0 : count_q + 32'd1;
    end
  end

  // PEND: a new match wins over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= FALSE;
    end else if (match) begin
      pend_q <= TRUE;
    end else if (wr && addr == TMR_STATUS && wdata[0]) begin
      pend_q <= FALSE;
    end
  end

  // Interrupt is a registered copy of PEND gated by IE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_flag_q <= FALSE;
    end else begin
      int_flag_q <= pend_q & ctrl_q[CTRL_IE];
    end
  end

  assign int_flag_o = int_flag_q;

  // Register read mux.
  always_comb begin
    rdata = '0;
    unique case (addr)
      TMR_CTRL:   rdata = {29'd0, ctrl_q};
      TMR_COUNT:  rdata = count_q;
      TMR_CMP:    rdata = cmp_q;
      TMR_STATUS: rdata = {31'd0, pend_q};
      default:    rdata = '0;
    endcase
  end

endmodule

// File: rtl/sys_bus_periph.sv
// System-bus peripheral block: decodes the timer (0x1xxx_xxxx) and GPIO (0x2xxx_xxxx) regions,
// muxes read data back to the CPU and holds the GPIO registers.
// GPIO is only present when SYS_BUS_GPIO_EN is defined; otherwise the 0x2 region is unmapped
// and the GPIO ports are tied off.
module sys_bus_periph
  import sys_bus_periph_pkg::*;
#(
  parameter int unsigned PRESCALE   = 16,
  parameter int unsigned GPIO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sys_bus_request,
  input  logic                  sys_bus_we,
  input  logic [31:0]           sys_bus_adr,
  input  logic [31:0]           sys_bus_wdata,
  output logic [31:0]           sys_bus_rdata,
  output logic                  int_flag_o,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe
);

  region_e     region;
  logic        rd;
  logic        timer_sel;
  logic [1:0]  word;
  logic [31:0] timer_rdata;
  logic [31:0] gpio_rdata;
  logic        unused_bits;

  assign region      = decode_region(sys_bus_adr);
  assign rd          = sys_bus_request & ~sys_bus_we;
  assign timer_sel   = sys_bus_request && (region == RegionTimer);
  assign word        = sys_bus_adr[3:2];
  assign unused_bits = ^{sys_bus_adr[1:0], sys_bus_wdata};

  sys_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel        (timer_sel),
    .we         (sys_bus_we),
    .addr       (word),
    .wdata      (sys_bus_wdata),
    .rdata      (timer_rdata),
    .int_flag_o (int_flag_o)
  );

`ifdef SYS_BUS_GPIO_EN
  logic [GPIO_WIDTH-1:0] out_q;
  logic [GPIO_WIDTH-1:0] dir_q;
  logic [GPIO_WIDTH-1:0] sync1_q;
  logic [GPIO_WIDTH-1:0] sync2_q;
  logic                  gpio_wr;

  assign gpio_wr = sys_bus_request && sys_bus_we && (region == RegionGpio);

  // Bus-writable pad output value and direction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      dir_q <= '0;
    end else if (gpio_wr) begin
      if (word == GPIO_OUT) out_q <= sys_bus_wdata[GPIO_WIDTH-1:0];
      if (word == GPIO_DIR) dir_q <= sys_bus_wdata[GPIO_WIDTH-1:0];
    end
  end

  // Two-flop synchronizer for the asynchronous pad inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
  end

  // GPIO register read mux; IN is read-only.
  always_comb begin
    gpio_rdata = '0;
    unique case (word)
      GPIO_OUT: gpio_rdata = 32'(out_q);
      GPIO_DIR: gpio_rdata = 32'(dir_q);
      GPIO_IN:  gpio_rdata = 32'(sync2_q);
      default:  gpio_rdata = '0;
    endcase
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
`else
  logic unused_gpio_in;

  assign unused_gpio_in = ^gpio_in;
  assign gpio_rdata     = '0;
  assign gpio_out       = '0;
  assign gpio_oe        = '0;
`endif

  // Read data is zero unless a read hits a mapped register.
  always_comb begin
    sys_bus_rdata = '0;
    if (rd) begin
      unique case (region)
        RegionTimer: sys_bus_rdata = timer_rdata;
        RegionGpio:  sys_bus_rdata = gpio_rdata;
        default:     sys_bus_rdata = '0;
      endcase
    end
  end

endmodule
